// File: rtl/compositor_pkg.sv
// rtl/compositor_pkg.sv - shared types and constants for the green-screen compositor
package compositor_pkg;

   localparam int ACTIVE_H     = 1280;
   localparam int ACTIVE_V     = 720;
   localparam int BRAM_LATENCY = 2;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pixel_t;

   typedef enum logic {
      ST_SYNC = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Per-pixel sideband carried alongside the background read
   typedef struct packed {
      pixel_t      fg;
      logic        mask;
      logic        active;
      logic        en;
      logic        valid;
      logic [10:0] h;
      logic [9:0]  v;
      logic        cnt_load;
      logic [20:0] cnt;
   } side_t;

   function automatic logic is_active(input logic [10:0] h, input logic [9:0] v);
      return (h < 11'(ACTIVE_H)) && (v < 10'(ACTIVE_V));
   endfunction

   function automatic logic is_last(input logic [10:0] h, input logic [9:0] v);
      return (h == 11'(ACTIVE_H - 1)) && (v == 10'(ACTIVE_V - 1));
   endfunction

endpackage

// File: rtl/pipe_delay.sv
// rtl/pipe_delay.sv - fixed-length register delay line
module pipe_delay #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 1
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out
);

   logic [WIDTH-1:0] stage_q [STAGES];

   // Shift data one stage per cycle; reset flushes every stage
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= data_in;
         for (int i = 1; i < STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign data_out = stage_q[STAGES-1];

endmodule

// File: rtl/green_compositor.sv
// rtl/green_compositor.sv - green-screen compositor with background BRAM and green-pixel counter
module green_compositor
   import compositor_pkg::*;
#(
   parameter int BG_WIDTH  = 320,
   parameter int BG_HEIGHT = 180,
   parameter int BG_SHIFT  = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        valid_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic [23:0] fg_pixel_in,
   input  logic        mask_in,
   input  logic        composite_en_in,
   output logic [16:0] bg_addr_out,
   input  logic [23:0] bg_data_in,
   output logic [23:0] pixel_out,
   output logic [10:0] hcount_out,
   output logic [9:0]  vcount_out,
   output logic        valid_out,
   output logic [20:0] green_count_out,
   output logic        count_valid_out
);

   state_t                   state_q;
   logic                     en_q;
   logic [20:0]              acc_q;
   logic [20:0]              acc_d;
   logic [16:0]              bg_addr_q;
   logic [16:0]              addr_d;
   logic [16:0]              row_s;
   logic [16:0]              col_s;
   logic                     frame_start;
   logic                     run_eff;
   logic                     active_in;
   logic                     en_eff;
   logic                     green_in;
   side_t                    s1_q;
   side_t                    s1_d;
   side_t                    s3;
   logic [$bits(side_t)-1:0] s3_vec;

   // Decode the incoming pixel: frame start, address, accumulator and stage-1 sideband
   always_comb begin
      frame_start = valid_in && (hcount_in == 11'd0) && (vcount_in == 10'd0);
      run_eff     = (state_q == ST_RUN) || frame_start;
      active_in   = is_active(hcount_in, vcount_in);
      en_eff      = frame_start ? composite_en_in : en_q;
      green_in    = valid_in && active_in && !mask_in;

      row_s = 17'(vcount_in >> BG_SHIFT);
      // Guard against a background smaller than the scaled screen
      if (row_s >= 17'(BG_HEIGHT)) begin
         row_s = 17'(BG_HEIGHT - 1);
      end
      col_s  = 17'(hcount_in >> BG_SHIFT);
      addr_d = active_in ? (17'(row_s * 17'(BG_WIDTH)) + col_s) : bg_addr_q;

      acc_d = acc_q;
      if (frame_start) begin
         acc_d = green_in ? 21'd1 : 21'd0;
      end else if (run_eff && green_in) begin
         acc_d = acc_q + 21'd1;
      end

      s1_d.fg       = fg_pixel_in;
      s1_d.mask     = mask_in;
      s1_d.active   = active_in;
      s1_d.en       = en_eff;
      s1_d.valid    = valid_in && run_eff;
      s1_d.h        = hcount_in;
      s1_d.v        = vcount_in;
      s1_d.cnt_load = valid_in && run_eff && is_last(hcount_in, vcount_in);
      s1_d.cnt      = acc_d;
   end

   // Frame-sync FSM and the per-frame latched compositing enable
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= ST_SYNC;
         en_q    <= 1'b1;
      end else begin
         if (frame_start) begin
            en_q <= composite_en_in;
         end
         case (state_q)
            ST_SYNC: if (frame_start) state_q <= ST_RUN;
            ST_RUN:  state_q <= ST_RUN;
            default: state_q <= ST_SYNC;
         endcase
      end
   end

   // Green-pixel accumulator for the frame in progress
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   // Stage 1: registered BRAM address and sideband
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         bg_addr_q <= '0;
         s1_q      <= '0;
      end else begin
         bg_addr_q <= addr_d;
         s1_q      <= s1_d;
      end
   end

   assign bg_addr_out = bg_addr_q;

   pipe_delay #(
      .WIDTH  ($bits(side_t)),
      .STAGES (BRAM_LATENCY)
   ) u_side_delay (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .data_in  (s1_q),
      .data_out (s3_vec)
   );

   assign s3 = s3_vec;

   // Output stage: pick foreground or background, blank outside the active region
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         pixel_out       <= '0;
         hcount_out      <= '0;
         vcount_out      <= '0;
         valid_out       <= 1'b0;
         green_count_out <= '0;
         count_valid_out <= 1'b0;
      end else begin
         if (!s3.active) begin
            pixel_out <= 24'h000000;
         end else if (s3.mask || !s3.en) begin
            pixel_out <= s3.fg;
         end else begin
            pixel_out <= bg_data_in;
         end
         hcount_out      <= s3.h;
         vcount_out      <= s3.v;
         valid_out       <= s3.valid;
         count_valid_out <= s3.cnt_load;
         if (s3.cnt_load) begin
            green_count_out <= s3.cnt;
         end
      end
   end

endmodule

// File: doc/green_compositor.md
GREEN_COMPOSITOR -- requirements
Module: green_compositor

Interface
REQ-001 SHALL have parameter BG_WIDTH, default 320, background image width in pixels.
REQ-002 SHALL have parameter BG_HEIGHT, default 180, background image height in pixels.
REQ-003 SHALL have parameter BG_SHIFT, default 2, log2 of the screen-to-background downscale factor.
REQ-004 SHALL have port clk_in, input, 1, single clock for all logic.
REQ-005 SHALL have port rst_in, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port valid_in, input, 1, pixel strobe for the current cycle.
REQ-007 SHALL have port hcount_in, input, 11, pixel column, 0..1279 active.
REQ-008 SHALL have port vcount_in, input, 10, pixel row, 0..719 active.
REQ-009 SHALL have port fg_pixel_in, input, 24, camera pixel {r,g,b}.
REQ-010 SHALL have port mask_in, input, 1, green-screen mask (0 = green/background, 1 = keep foreground).
REQ-011 SHALL have port composite_en_in, input, 1, compositing enable.
REQ-012 SHALL have port bg_addr_out, output, 17, background BRAM read address.
REQ-013 SHALL have port bg_data_in, input, 24, BRAM read data {r,g,b}, fixed 2-cycle read latency.
REQ-014 SHALL have port pixel_out, output, 24, composited pixel.
REQ-015 SHALL have ports hcount_out (11) and vcount_out (10), outputs, counts aligned to pixel_out.
REQ-016 SHALL have port valid_out, output, 1, strobe aligned to pixel_out.
REQ-017 SHALL have port green_count_out, output, 21, count of mask_in==0 active pixels in the last complete frame.
REQ-018 SHALL have port count_valid_out, output, 1, one-cycle pulse when green_count_out updates.

Function
REQ-019 SHALL implement a two-state FSM: SYNC and RUN.
REQ-020 SYNC SHALL move to RUN on valid_in with hcount_in==0 and vcount_in==0; in SYNC, valid_out SHALL be forced to 0.
REQ-021 RUN SHALL remain in RUN until reset; there is no other transition.
REQ-022 bg_addr_out SHALL be registered at one cycle after input and equal (vcount_in>>BG_SHIFT)*BG_WIDTH + (hcount_in>>BG_SHIFT); the multiply SHALL be a constant-width 17-bit result.
REQ-023 Input-to-output latency SHALL be exactly 4 cycles for pixel_out, hcount_out, vcount_out and valid_out; fg_pixel_in, mask_in and counts SHALL be delay-matched to bg_data_in.
REQ-024 Inside the active region, the output pixel SHALL be fg when mask==1 or when the compositing enable is latched to 0, and bg_data otherwise.
REQ-025 Outside the active region (hcount≥1280 or vcount≥720), pixel_out SHALL be 24'h000000, and bg_addr_out SHALL hold its previous value.
REQ-026 composite_en_in SHALL be sampled only at frame start (valid, 0,0); a mid-frame change SHALL take effect at the next frame.
REQ-027 In RUN, a 21-bit accumulator SHALL count valid active pixels with mask_in==0.
REQ-028 On the valid pixel (1279,719), the accumulator value including that pixel SHALL be loaded into green_count_out, and count_valid_out SHALL pulse aligned with that pixel's valid_out.
REQ-029 The accumulator SHALL clear at frame start; the frame-start pixel itself SHALL count.
REQ-030 Cycles with valid_in==0 SHALL not advance the accumulator; the pipeline SHALL advance every cycle regardless of valid.
REQ-031 A frame start seen before (1279,719) SHALL clear the accumulator without updating green_count_out.

Reset
REQ-032 On rst_in, FSM SHALL be SYNC, the latched enable SHALL be 1, and all pipeline registers, counters and outputs SHALL be 0, with bg_addr_out, pixel_out, valid_out, green_count_out and count_valid_out all 0.
REQ-033 Reset asserted mid-frame SHALL discard in-flight pixels; no valid_out SHALL appear until a new frame start is seen after release.

Structure
REQ-034 Package compositor_pkg SHALL hold pixel_t (24-bit packed struct r,g,b), ACTIVE_H=1280, ACTIVE_V=720, BRAM_LATENCY=2 and the FSM state enum.
REQ-035 Delay matching SHALL use one sub-module, pipe_delay (parameters WIDTH, STAGES), with an asynchronous active-high reset.

Verification
REQ-036 Reset, then frame start with mask=1 and fg=0x123456 -> pixel_out=0x123456 exactly 4 cycles later, valid_out=1.
REQ-037 Input (hcount 8, vcount 4) with mask=0 -> bg_addr_out=1*320+2=322 one cycle later; the model BRAM value 0xABCDEF appears on pixel_out at +4.
REQ-038 Full frame with every 4th active pixel mask=0 -> green_count_out=230400 with a single count_valid_out pulse aligned to pixel (1279,719).
REQ-039 Toggle composite_en_in to 0 mid-frame -> the remaining pixels of that frame are still composited; the next frame outputs fg everywhere.
REQ-040 Pixel at hcount 1300 -> pixel_out=0 and bg_addr_out unchanged.
REQ-041 Assert rst_in mid-frame, release, feed pixels without a frame start -> valid_out stays 0 until (0,0) arrives, then output resumes at +4.
